// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the memory stage and a word-wide memory.
// Byte-addressed byte/half/word requests become word accesses; loads are
// sign- or zero-extended, sub-word stores are read-modify-write because the
// memory has no byte enables. Read data from the memory returns on mem_rdata
// one cycle after the address is presented. One request in flight at a time.
module lsu_mem_ctrl #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;   // byte offset within the word
  logic [15:0] wdata_q;  // only the low half is needed for sub-word merges

  logic [1:0]  req_size_n;
  logic        req_misaligned;
  logic [31:0] req_addr_al;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Decode the incoming request: fold size 3 into word, detect misalignment,
  // and form the force-aligned address used when misalignment is not trapped.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_size_n     = (req_size == 2'd3) ? SZ_WORD : req_size;
    req_misaligned = ((req_size_n == SZ_HALF) && req_addr[0]) ||
                     ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_addr_al    = req_addr;
    if (req_size_n == SZ_HALF)      req_addr_al[0]   = 1'b0;
    else if (req_size_n == SZ_WORD) req_addr_al[1:0] = 2'b00;
  end

  // Lane extraction with extension for loads, and the merged word for stores.
  always_comb begin
    lane_b   = mem_rdata[{lane_q, 3'b000} +: 8];
    lane_h   = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    merged   = mem_rdata;
    case (size_q)
      SZ_BYTE: begin
        load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  // Controller FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_rw     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      lane_q     <= 2'b00;
      wdata_q    <= 16'd0;
    end else begin
      mem_rw <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size_n;
            lane_q    <= req_addr_al[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (MISALIGN_TRAP && req_misaligned) begin
              // Trap without touching the memory port.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_we && (req_size_n == SZ_WORD)) begin
              state     <= WR;
              mem_addr  <= {2'b00, req_addr_al[31:2]};
              mem_wdata <= req_wdata;
              mem_rw    <= 1'b1;
            end else begin
              state    <= RD;
              mem_addr <= {2'b00, req_addr_al[31:2]};
            end
          end
        end
        RD: state <= DATA;
        DATA: begin
          if (we_q) begin
            state     <= WR;
            mem_wdata <= merged;
            mem_rw    <= 1'b1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_val;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: two instances (trapping and force-aligning), each
// with a 64-word memory that registers read data and gives reset priority
// over writes. Expected results come from a byte-array model of memory.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 20;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b1;
  logic        use_b = 1'b0;

  logic        req_ready_a, resp_valid_a, resp_err_a, mem_rw_a;
  logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        req_ready_b, resp_valid_b, resp_err_b, mem_rw_b;
  logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  logic        sel_ready, sel_valid, sel_err, sel_rw;
  logic [31:0] sel_rdata;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [7:0]  ref_bytes [256];

  int n_vec = 0;
  int n_bad = 0;
  int rw_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MISALIGN_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_a), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rw(mem_rw_a), .mem_rdata(mem_rdata_a)
  );

  lsu_mem_ctrl #(.MISALIGN_TRAP(1'b0)) dut_align (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_b), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rw(mem_rw_b), .mem_rdata(mem_rdata_b)
  );

  // Word memories: registered read, reset has priority over write, low 6 index bits used.
  always @(posedge clk) begin
    if (reset) mem_rdata_a <= 32'd0;
    else begin
      if (mem_rw_a) mem_a[mem_addr_a[5:0]] <= mem_wdata_a;
      mem_rdata_a <= mem_a[mem_addr_a[5:0]];
    end
  end

  always @(posedge clk) begin
    if (reset) mem_rdata_b <= 32'd0;
    else begin
      if (mem_rw_b) mem_b[mem_addr_b[5:0]] <= mem_wdata_b;
      mem_rdata_b <= mem_b[mem_addr_b[5:0]];
    end
  end

  always_comb begin
    sel_ready = use_b ? req_ready_b  : req_ready_a;
    sel_valid = use_b ? resp_valid_b : resp_valid_a;
    sel_err   = use_b ? resp_err_b   : resp_err_a;
    sel_rw    = use_b ? mem_rw_b     : mem_rw_a;
    sel_rdata = use_b ? resp_rdata_b : resp_rdata_a;
  end

  // Count cycles with the memory write enable high on the selected instance.
  always @(negedge clk) if (sel_rw) rw_cnt <= rw_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model over a 256-byte little-endian memory (aliasing on address bits above 7).
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err,
                       output int lat, output int writes);
    int nbytes;
    int base;
    logic [31:0] val;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base   = int'(addr & 32'hFF);
    rdata  = 32'd0;
    err    = 1'b0;
    writes = 0;
    if ((base % nbytes) != 0) begin
      err = 1'b1;
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[base + i] = wdata[8*i +: 8];
      lat    = (nbytes == 4) ? 2 : 4;
      writes = 1;
    end else begin
      val = 32'd0;
      for (int i = 0; i < nbytes; i++) val = val | (32'(ref_bytes[base + i]) << (8*i));
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | (32'hFFFF_FFFF << (8*nbytes));
      rdata = val;
      lat   = 3;
    end
  endtask

  // Issue one request to the selected instance; returns edges from accept to resp_valid.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, output int lat);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    guard = 0;
    while (!sel_ready && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_addr = 32'hDEAD_BEE3; req_wdata = 32'hFFFF_FFFF; req_size = 2'd1; req_we = ~we;
    lat = 1;
    while (!sel_valid && lat <= TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    int lat;
    int w0;
    logic [31:0] r;
    logic e;
    w0 = rw_cnt;
    send(v.we, v.size, v.uns, v.addr, v.wdata, lat);
    r = sel_rdata;
    e = sel_err;
    check({tag, ".latency"}, lat, v.exp_lat);
    check({tag, ".rdata"}, r, v.exp_rdata);
    check({tag, ".err"}, {31'd0, e}, {31'd0, v.exp_err});
    check({tag, ".writes"}, rw_cnt - w0, v.exp_wr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"},  {31'd0, req_ready_a},  32'd1);
    check({tag, ".resp_valid"}, {31'd0, resp_valid_a}, 32'd0);
    check({tag, ".resp_err"},   {31'd0, resp_err_a},   32'd0);
    check({tag, ".mem_rw"},     {31'd0, mem_rw_a},     32'd0);
    check({tag, ".resp_rdata"}, resp_rdata_a, 32'd0);
    check({tag, ".mem_addr"},   mem_addr_a,   32'd0);
    check({tag, ".mem_wdata"},  mem_wdata_a,  32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] dr;
    logic de;
    int dl, dw, lat;
    logic [31:0] held;
    logic saw_resp;

    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Bring both memories to a known state through the controllers themselves.
    for (int i = 0; i < 64; i++) send(1'b1, 2'd2, 1'b0, 32'(i*4), 32'd0, lat);
    use_b = 1'b1;
    for (int i = 0; i < 64; i++) send(1'b1, 2'd2, 1'b0, 32'(i*4), 32'd0, lat);
    send(1'b1, 2'd2, 1'b0, 32'h04, 32'h8899_AABB, lat);
    use_b = 1'b0;

    // Directed table on the trapping instance
    //                 we    size  uns   addr        wdata          rdata          err  lat wr
    tbl.push_back(vec_t'{1'b1, 2'd2, 1'b0, 32'h004, 32'h8899_AABB, 32'h0000_0000, 1'b0, 2, 1});
    tbl.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h8899_AABB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h007, 32'h0,         32'hFFFF_FF88, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h007, 32'h0,         32'h0000_0088, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd1, 1'b0, 32'h004, 32'h0,         32'hFFFF_AABB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd1, 1'b1, 32'h006, 32'h0,         32'h0000_8899, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b1, 2'd0, 1'b0, 32'h005, 32'hFFFF_FF11, 32'h0000_0000, 1'b0, 4, 1});
    tbl.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h8899_11BB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b1, 2'd1, 1'b0, 32'h006, 32'hABCD_2233, 32'h0000_0000, 1'b0, 4, 1});
    tbl.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h004, 32'h0,         32'h2233_11BB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h006, 32'h0,         32'h0000_0000, 1'b1, 1, 0});
    tbl.push_back(vec_t'{1'b1, 2'd1, 1'b0, 32'h005, 32'h5555_5555, 32'h0000_0000, 1'b1, 1, 0});
    tbl.push_back(vec_t'{1'b1, 2'd3, 1'b0, 32'h00E, 32'h7777_7777, 32'h0000_0000, 1'b1, 1, 0});
    tbl.push_back(vec_t'{1'b0, 2'd3, 1'b0, 32'h004, 32'h0,         32'h2233_11BB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd2, 1'b0, 32'h104, 32'h0,         32'h2233_11BB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd0, 1'b0, 32'h004, 32'h0,         32'hFFFF_FFBB, 1'b0, 3, 0});
    tbl.push_back(vec_t'{1'b0, 2'd0, 1'b1, 32'h107, 32'h0,         32'h0000_0022, 1'b0, 3, 0});
    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, dr, de, dl, dw);
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Force-aligning instance: misaligned accesses proceed on the aligned word.
    use_b = 1'b1;
    apply(vec_t'{1'b0, 2'd2, 1'b0, 32'h006, 32'h0, 32'h8899_AABB, 1'b0, 3, 0}, "align_lw");
    apply(vec_t'{1'b0, 2'd1, 1'b0, 32'h005, 32'h0, 32'hFFFF_AABB, 1'b0, 3, 0}, "align_lh");
    apply(vec_t'{1'b1, 2'd2, 1'b0, 32'h00B, 32'h1234_5678, 32'h0, 1'b0, 2, 1}, "align_sw");
    apply(vec_t'{1'b0, 2'd2, 1'b0, 32'h008, 32'h0, 32'h1234_5678, 1'b0, 3, 0}, "align_rb");
    use_b = 1'b0;

    // Backpressure: response held for 5 cycles with resp_ready low.
    model(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, dr, de, dl, dw);
    resp_ready = 1'b0;
    send(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, lat);
    check("bp.latency", lat, 32'd3);
    held = resp_rdata_a;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.valid%0d", i), {31'd0, resp_valid_a}, 32'd1);
      check($sformatf("bp.rdata%0d", i), resp_rdata_a, dr);
      check($sformatf("bp.ready%0d", i), {31'd0, req_ready_a}, 32'd0);
    end
    check("bp.held", resp_rdata_a, held);
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp.release_valid", {31'd0, resp_valid_a}, 32'd0);
    check("bp.release_ready", {31'd0, req_ready_a}, 32'd1);

    // Reset while an sb is in WR: memory unchanged, request dropped.
    model(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, dr, de, dl, dw);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h004; req_wdata = 32'h0000_00EE;
    req_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_wr.in_wr", {31'd0, mem_rw_a}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_wr");
    reset = 1'b0;
    saw_resp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid_a) saw_resp = 1'b1;
    end
    check("rst_wr.no_resp", {31'd0, saw_resp}, 32'd0);
    apply(vec_t'{1'b0, 2'd2, 1'b0, 32'h004, 32'h0, dr, 1'b0, 3, 0}, "rst_wr.readback");

    // Randomized requests against the reference model.
    for (int i = 0; i < 300; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.size  = 2'($urandom_range(0, 3));
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = 32'($urandom_range(0, 511));
      v.wdata = $urandom;
      model(v.we, v.size, v.uns, v.addr, v.wdata, v.exp_rdata, v.exp_err, v.exp_lat, v.exp_wr);
      apply(v, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
